// File: rtl/chdr_conv_arbiter.sv
// chdr_conv_arbiter
// Packet-granular two-way arbiter that feeds one CHDR stream into the
// 8sc-to-16sc converter. Each grant lasts for at least one whole packet. A
// per-requester quota lets the last-served input keep the grant for several
// back-to-back packets. The data path is a zero-latency mux. Only the grant
// decision is registered, so every packet is preceded by one idle cycle.
module chdr_conv_arbiter #(
    parameter logic [7:0] BASE = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,

    input  logic [63:0] i0_tdata,
    input  logic        i0_tlast,
    input  logic        i0_tvalid,
    output logic        i0_tready,

    input  logic [63:0] i1_tdata,
    input  logic        i1_tlast,
    input  logic        i1_tvalid,
    output logic        i1_tready,

    output logic [63:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,

    output logic [15:0] pkt_cnt0,
    output logic [15:0] pkt_cnt1,
    output logic        busy
);

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS0 = 2'd1,
        PASS1 = 2'd2
    } state_t;

    // Quota counter increment, saturating at its maximum.
    function automatic logic [7:0] qcnt_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // Reset synchroniser: asserts immediately, releases two clocks after reset_n rises.
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst_n;

    // Shift ones into the synchroniser once reset_n is released.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // Synchroniser flops, cleared directly by the external reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    state_t      state_q, state_d;
    logic        en0_q, en0_d;
    logic        en1_q, en1_d;
    logic [7:0]  quota_q, quota_d;
    logic [7:0]  qcnt_q, qcnt_d;
    logic        last_q, last_d;
    logic [15:0] pkt_cnt0_q, pkt_cnt0_d;
    logic [15:0] pkt_cnt1_q, pkt_cnt1_d;
    logic        busy_q, busy_d;

    logic [7:0]  quota_eff;
    logic        elig0, elig1, elig_last, elig_other;
    logic        unused_set_bits;

    // Register fields that have no function are tied off here.
    assign unused_set_bits = ^{set_data[31:16], set_data[7:2]};

    // Next-state logic: register writes, grant decision in IDLE, packet end in PASSk.
    always_comb begin
        state_d    = state_q;
        en0_d      = en0_q;
        en1_d      = en1_q;
        quota_d    = quota_q;
        qcnt_d     = qcnt_q;
        last_d     = last_q;
        pkt_cnt0_d = pkt_cnt0_q;
        pkt_cnt1_d = pkt_cnt1_q;

        if (set_stb && (set_addr == BASE)) begin
            en0_d   = set_data[0];
            en1_d   = set_data[1];
            quota_d = set_data[15:8];
        end

        quota_eff  = (quota_q == 8'd0) ? 8'd1 : quota_q;
        elig0      = i0_tvalid & en0_q;
        elig1      = i1_tvalid & en1_q;
        elig_last  = last_q ? elig1 : elig0;
        elig_other = last_q ? elig0 : elig1;

        case (state_q)
            IDLE: begin
                // A zero count in IDLE means the last-served requester has not
                // finished a packet under its grant. That happens only after reset,
                // so it holds no credit to retain, and the round robin starts at 0.
                if (elig_last && (qcnt_q != 8'd0) && (qcnt_q < quota_eff)) begin
                    state_d = last_q ? PASS1 : PASS0;
                end else if (elig_other) begin
                    state_d = last_q ? PASS0 : PASS1;
                    last_d  = ~last_q;
                    qcnt_d  = 8'd0;
                end else if (elig_last) begin
                    state_d = last_q ? PASS1 : PASS0;
                    qcnt_d  = 8'd0;
                end
            end
            PASS0: begin
                if (i0_tvalid && i0_tlast && o_tready) begin
                    state_d    = IDLE;
                    pkt_cnt0_d = pkt_cnt0_q + 16'd1;
                    qcnt_d     = qcnt_inc(qcnt_q);
                end
            end
            PASS1: begin
                if (i1_tvalid && i1_tlast && o_tready) begin
                    state_d    = IDLE;
                    pkt_cnt1_d = pkt_cnt1_q + 16'd1;
                    qcnt_d     = qcnt_inc(qcnt_q);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // FSM and control state; all registered outputs are updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            en0_q      <= 1'b0;
            en1_q      <= 1'b0;
            quota_q    <= 8'd0;
            qcnt_q     <= 8'd0;
            last_q     <= 1'b1;
            pkt_cnt0_q <= 16'd0;
            pkt_cnt1_q <= 16'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            en0_q      <= en0_d;
            en1_q      <= en1_d;
            quota_q    <= quota_d;
            qcnt_q     <= qcnt_d;
            last_q     <= last_d;
            pkt_cnt0_q <= pkt_cnt0_d;
            pkt_cnt1_q <= pkt_cnt1_d;
            busy_q     <= busy_d;
        end
    end

    // Zero-latency stream mux steered by the registered grant.
    always_comb begin
        o_tdata   = {DATA_W{1'b0}};
        o_tlast   = 1'b0;
        o_tvalid  = 1'b0;
        i0_tready = 1'b0;
        i1_tready = 1'b0;
        case (state_q)
            PASS0: begin
                o_tdata   = i0_tdata;
                o_tlast   = i0_tlast;
                o_tvalid  = i0_tvalid;
                i0_tready = o_tready;
            end
            PASS1: begin
                o_tdata   = i1_tdata;
                o_tlast   = i1_tlast;
                o_tvalid  = i1_tvalid;
                i1_tready = o_tready;
            end
            default: ;
        endcase
    end

    assign pkt_cnt0 = pkt_cnt0_q;
    assign pkt_cnt1 = pkt_cnt1_q;
    assign busy     = busy_q;

endmodule

// File: doc/chdr_conv_arbiter.md
CHDR_CONV_ARBITER -- requirements
Module: chdr_conv_arbiter

Interface
REQ-001 Parameter BASE, default 0, settings-bus address of the control register.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 set_stb / set_addr / set_data  input  1/8/32  settings bus; write when set_stb=1 and set_addr=BASE.
REQ-005 i0_tdata / i0_tlast / i0_tvalid / i0_tready  in/in/in/out  64/1/1/1  CHDR requester 0.
REQ-006 i1_tdata / i1_tlast / i1_tvalid / i1_tready  in/in/in/out  64/1/1/1  CHDR requester 1.
REQ-007 o_tdata / o_tlast / o_tvalid / o_tready  out/out/out/in  64/1/1/1  shared stream into the 8sc-to-16sc converter.
REQ-008 pkt_cnt0 / pkt_cnt1  output  16/16  packets forwarded per requester.
REQ-009 busy  output  1  high while a packet is in flight.

Function
REQ-010 Control register fields: bit0 en0, bit1 en1, bits[15:8] quota (packets per grant; 0 is treated as 1); other bits ignored.
REQ-011 Register write takes effect on the cycle after set_stb; writes during a packet do not abort that packet.
REQ-012 FSM states: IDLE, PASS0, PASS1.
REQ-013 IDLE: o_tvalid=0, i0_tready=0, i1_tready=0; grant evaluated combinationally, next state registered (one-cycle arbitration bubble).
REQ-014 Candidate k is eligible when ik_tvalid=1 and enk=1.
REQ-015 Grant: if last-served requester is eligible and its quota count < quota, it retains the grant; otherwise the other eligible requester is granted; if only one is eligible, it is granted and its quota count restarts.
REQ-016 On a grant change, the quota count resets to 0 and last-served is updated to the new requester.
REQ-017 PASSk: o_tdata=ik_tdata, o_tlast=ik_tlast, o_tvalid=ik_tvalid, ik_tready=o_tready, other input's tready=0; zero-latency combinational path.
REQ-018 A packet is never interrupted: the PASSk->IDLE transition occurs only on the beat with ik_tvalid & ik_tlast & o_tready.
REQ-019 On that beat: pkt_cntk increments by 1 (wraps 0xFFFF->0); quota count increments (saturating at 255).
REQ-020 enk deasserted mid-packet: current packet completes; requester k is ineligible from the next IDLE.
REQ-021 Both requesters eligible at first arbitration after reset: requester 0 wins (last-served resets to 1).
REQ-022 busy = 1 in PASS0/PASS1, 0 in IDLE.
REQ-023 No beat is duplicated, dropped or reordered; o_tvalid never deasserts mid-packet unless the granted input's tvalid does.

Reset
REQ-024 reset_n low: state IDLE, control register 0x0000_0000 (both disabled, quota 1), quota count 0, last-served 1, pkt_cnt0=pkt_cnt1=0, busy=0, o_tvalid=0, i0_tready=i1_tready=0.
REQ-025 Reset asserted mid-packet: immediate return to IDLE; the partial packet is not completed, and the upstream must re-send from the header.
REQ-026 Outputs reach reset values asynchronously; reset deassertion is synchronised to clk internally.

Verification
REQ-027 en0=en1=1, quota=1, both inputs continuously offering 3-beat packets -> output alternates 0,1,0,1; one idle cycle between packets; pkt_cnt0=pkt_cnt1 after each pair.
REQ-028 quota=3, both offering -> three packets from 0, then three from 1; pkt_cnt0=3 when the first packet from 1 starts.
REQ-029 en1=0, both offering -> only requester 0 forwarded; i1_tready stays 0; pkt_cnt1 stays 0.
REQ-030 o_tready toggled randomly during a 10-beat packet -> output beats equal input beats in order; tlast only on beat 10; no grant switch mid-packet.
REQ-031 en0 cleared on beat 2 of a requester-0 packet -> packet completes, next grant goes to 1.
REQ-032 reset_n pulsed low mid-packet -> busy=0, o_tvalid=0 the same cycle; counters 0; the next grant goes to requester 0.
